pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Sequences the pipeline-register and PC load enables for the 5-stage pipeline.
- Combines three stall/flush sources into one enable/bubble/flush output set:
  - the load-use hazard flag from the forwarding unit;
  - branch-taken from EX;
  - the multi-cycle data-memory busy flag.
- Adds a bounded memory-wait FSM with timeout, a multi-cycle branch flush, and optional stall/flush performance counters.

Parameters:
- MEM_WAIT_MAX, 15: maximum number of busy cycles counted in MEM_WAIT before the timeout error; range 1..255.
- FLUSH_CYCLES, 1: number of cycles IFID_flush is asserted per taken branch; range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- load_hazard  in  1  load-use hazard request from the forwarding unit
- branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory not ready; pipeline must freeze
- PC_LE  out  1  PC load enable
- IFID_LE  out  1  IF/ID load enable
- IDEX_LE  out  1  ID/EX load enable
- EXMEM_LE  out  1  EX/MEM load enable
- MEMWB_LE  out  1  MEM/WB load enable
- control_select  out  1  1 = inject NOP control word into ID/EX
- IFID_flush  out  1  clear IF/ID contents
- timeout_err  out  1  sticky memory-wait timeout
- stall_count  out  16  cycles with PC_LE=0 (PERF_CNT_EN only)
- flush_count  out  16  cycles with IFID_flush=1 (PERF_CNT_EN only)

Behaviour:
- While reset_n=0, regardless of inputs:
  - state=RUN; all counters 0; timeout_err=0; FLUSH resume count 0.
  - All five LE outputs =1; control_select=0; IFID_flush=0.
- States: RUN, FLUSH, MEM_WAIT, ERROR; 2-bit encoding.
- RUN outputs are Mealy; MEM_WAIT and ERROR outputs are Moore.
- RUN (priority mem_busy > branch_taken > load_hazard):
  - mem_busy=1:
    - This cycle all LE=0, control_select=0, IFID_flush=0.
    - wait_cnt<=1; return_state<=RUN; next state MEM_WAIT.
  - branch_taken=1:
    - This cycle IFID_flush=1, control_select=1, all LE=1.
    - If FLUSH_CYCLES>1: flush_rem<=FLUSH_CYCLES-1; next state FLUSH.
  - load_hazard=1:
    - This cycle PC_LE=0, IFID_LE=0, control_select=1; IDEX_LE, EXMEM_LE, MEMWB_LE =1.
    - Stay in RUN. Single bubble per asserted cycle; the flag drops once the load leaves EX.
  - Otherwise: all LE=1, control_select=0, IFID_flush=0.
- FLUSH:
  - Outputs: IFID_flush=1, control_select=1, all LE=1; load_hazard ignored.
  - flush_rem decrements; when flush_rem reaches 1, next state RUN.
  - branch_taken=1 reloads flush_rem<=FLUSH_CYCLES-1.
  - mem_busy=1 takes priority:
    - Outputs as RUN mem_busy case.
    - flush_rem held; return_state<=FLUSH; next state MEM_WAIT.
- MEM_WAIT:
  - Outputs: all LE=0, control_select=0, IFID_flush=0.
  - mem_busy=1 and wait_cnt<MEM_WAIT_MAX: wait_cnt+1.
  - mem_busy=1 and wait_cnt==MEM_WAIT_MAX: next state ERROR.
  - mem_busy=0: next state return_state. Fixed 1-cycle release latency.
  - branch_taken and load_hazard are ignored in MEM_WAIT (the pipeline is frozen, so sources hold).
- ERROR:
  - All LE=0; timeout_err=1 (registered; first visible the cycle ERROR is entered).
  - Exit only via reset.
- wait_cnt is 8 bits; flush_rem is 3 bits.
- Reset asserted mid-MEM_WAIT or mid-FLUSH aborts immediately with no residual flush.

Optional Feature:
- PERF_CNT_EN defined:
  - stall_count increments on every cycle with PC_LE=0.
  - flush_count increments on every cycle with IFID_flush=1.
  - Both are 16-bit and saturate at 16'hFFFF; both clear on reset.
- PERF_CNT_EN undefined: stall_count and flush_count are tied to 0; no counter flops.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN, FLUSH, MEM_WAIT, ERROR);
  - LE_ALL_ON / LE_ALL_OFF 5-bit constants;
  - PERF_W=16.
- One natural sub-module, sat_counter (width parameter, inc, clear, saturating), instantiated twice under PERF_CNT_EN.

Test Plan:
- Reset: reset_n=0 with load_hazard=branch_taken=mem_busy=1 -> all LE=1, control_select=0, IFID_flush=0, timeout_err=0, counters 0.
- load_hazard=1 for 1 cycle in RUN -> same cycle PC_LE=0, IFID_LE=0, control_select=1, IDEX_LE=1; next cycle all LE=1; stall_count=1.
- mem_busy=1 on cycles 0-2, then 0 -> all LE=0 on cycles 0-3, all LE=1 on cycle 4; stall_count=4.
- MEM_WAIT_MAX=4, mem_busy held high from cycle 0 -> ERROR entered, timeout_err=1 on cycle 5 and held; LE stay 0 until reset_n pulses.
- FLUSH_CYCLES=3, branch_taken on cycle 0, mem_busy=1 on cycle 1 only:
  - IFID_flush=1 on cycle 0;
  - freeze on cycles 1-2;
  - IFID_flush=1 on cycles 3-4;
  - RUN on cycle 5; flush_count=3.
- load_hazard=1 and branch_taken=1 in the same cycle -> PC_LE=1, IFID_flush=1, control_select=1 (branch wins).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    // Load-enable vectors ordered {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}
    localparam logic [4:0] LE_ALL_ON  = 5'b11111;
    localparam logic [4:0] LE_ALL_OFF = 5'b00000;
    localparam logic [4:0] LE_BUBBLE  = 5'b00111;

    localparam int PERF_W = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Only compiled when PERF_CNT_EN is defined, since nothing else uses it.
`ifdef PERF_CNT_EN
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones, clear synchronously or on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: merges load-use hazard, taken branch and
// data-memory busy into PC / pipeline-register enables, bubble and flush.
// Optional feature macro: PERF_CNT_EN enables the stall/flush counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_hazard,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              PC_LE,
    output logic              IFID_LE,
    output logic              IDEX_LE,
    output logic              EXMEM_LE,
    output logic              MEMWB_LE,
    output logic              control_select,
    output logic              IFID_flush,
    output logic              timeout_err,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count
);

    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_WAIT_MAX);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     return_state;
    logic [7:0] wait_cnt;
    logic [2:0] flush_rem;
    logic [4:0] le_vec;

    // State sequencing: memory freeze, multi-cycle flush and sticky timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            return_state <= RUN;
            wait_cnt     <= 8'd0;
            flush_rem    <= 3'd0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        wait_cnt     <= 8'd1;
                        return_state <= RUN;
                        state        <= MEM_WAIT;
                    end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                        flush_rem <= FLUSH_RELOAD;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        wait_cnt     <= 8'd1;
                        return_state <= FLUSH;
                        state        <= MEM_WAIT;
                    end else if (branch_taken) begin
                        flush_rem <= FLUSH_RELOAD;
                    end else if (flush_rem <= 3'd1) begin
                        state <= RUN;
                    end else begin
                        flush_rem <= flush_rem - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        if (wait_cnt < WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end else begin
                            state       <= ERROR;
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        state <= return_state;
                    end
                end
                ERROR: begin
                    timeout_err <= 1'b1;
                end
            endcase
        end
    end

    // Enable/bubble/flush decode; reset forces a free-running pipeline
    always_comb begin
        le_vec         = LE_ALL_ON;
        control_select = 1'b0;
        IFID_flush     = 1'b0;
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        le_vec = LE_ALL_OFF;
                    end else if (branch_taken) begin
                        control_select = 1'b1;
                        IFID_flush     = 1'b1;
                    end else if (load_hazard) begin
                        le_vec         = LE_BUBBLE;
                        control_select = 1'b1;
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        le_vec = LE_ALL_OFF;
                    end else begin
                        control_select = 1'b1;
                        IFID_flush     = 1'b1;
                    end
                end
                MEM_WAIT: le_vec = LE_ALL_OFF;
                ERROR:    le_vec = LE_ALL_OFF;
            endcase
        end
    end

    assign {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_LE} = le_vec;

`ifdef PERF_CNT_EN
    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (~PC_LE),
        .count   (stall_count)
    );

    sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (IFID_flush),
        .count   (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

    localparam int MAX_WAIT = 4;
    localparam int NFLUSH   = 3;

    logic        clk;
    logic        reset_n;
    logic        load_hazard;
    logic        branch_taken;
    logic        mem_busy;
    logic        PC_LE;
    logic        IFID_LE;
    logic        IDEX_LE;
    logic        EXMEM_LE;
    logic        MEMWB_LE;
    logic        control_select;
    logic        IFID_flush;
    logic        timeout_err;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checkCount;
    int passCount;

    // Behavioural model: pipeline either dead (timed out), frozen on memory,
    // owing some further flush cycles, or running freely.
    bit m_dead;
    bit m_frozen;
    int m_busy_run;
    int m_flush_left;
    int m_stalls;
    int m_flushes;

    pipeline_stall_controller #(
        .MEM_WAIT_MAX (MAX_WAIT),
        .FLUSH_CYCLES (NFLUSH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_hazard    (load_hazard),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .PC_LE          (PC_LE),
        .IFID_LE        (IFID_LE),
        .IDEX_LE        (IDEX_LE),
        .EXMEM_LE       (EXMEM_LE),
        .MEMWB_LE       (MEMWB_LE),
        .control_select (control_select),
        .IFID_flush     (IFID_flush),
        .timeout_err    (timeout_err),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and tally it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_dead       = 0;
        m_frozen     = 0;
        m_busy_run   = 0;
        m_flush_left = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    // Drive one clock cycle of inputs, check outputs at the negedge, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input bit rst_n_i, input bit lh, input bit bt, input bit mb);
        logic [4:0] exp_le;
        bit         exp_cs;
        bit         exp_fl;
        int         exp_sc;
        int         exp_fc;

        reset_n      = rst_n_i;
        load_hazard  = lh;
        branch_taken = bt;
        mem_busy     = mb;
        if (!rst_n_i) modelReset();

        exp_le = 5'b11111;
        exp_cs = 0;
        exp_fl = 0;
        if (rst_n_i) begin
            if (m_dead || m_frozen || mb) begin
                exp_le = 5'b00000;
            end else if (bt || (m_flush_left > 0)) begin
                exp_cs = 1;
                exp_fl = 1;
            end else if (lh) begin
                exp_le = 5'b00111;
                exp_cs = 1;
            end
        end

`ifdef PERF_CNT_EN
        exp_sc = m_stalls;
        exp_fc = m_flushes;
`else
        exp_sc = 0;
        exp_fc = 0;
`endif

        @(negedge clk);
        checkOutput("load_enables", 32'({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_LE}), 32'(exp_le));
        checkOutput("control_select", 32'(control_select), 32'(exp_cs));
        checkOutput("IFID_flush", 32'(IFID_flush), 32'(exp_fl));
        checkOutput("timeout_err", 32'(timeout_err), 32'(m_dead));
        checkOutput("stall_count", 32'(stall_count), 32'(exp_sc));
        checkOutput("flush_count", 32'(flush_count), 32'(exp_fc));

        @(posedge clk);
        if (rst_n_i) begin
            if (exp_le[4] == 1'b0 && m_stalls < 65535) m_stalls++;
            if (exp_fl && m_flushes < 65535) m_flushes++;
            if (m_dead) begin
                // only reset recovers
            end else if (m_frozen) begin
                if (mb) begin
                    m_busy_run++;
                    if (m_busy_run == MAX_WAIT + 1) m_dead = 1;
                end else begin
                    m_frozen = 0;
                end
            end else if (mb) begin
                m_frozen   = 1;
                m_busy_run = 1;
            end else if (bt) begin
                m_flush_left = NFLUSH - 1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
        #1;
    endtask

    initial begin
        int busy_pct;
        checkCount = 0;
        passCount  = 0;
        modelReset();

        // Reset with every request asserted
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 1, 1);

        // Single load-use bubble
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);

        // Three busy cycles then release
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

        // Taken branch with a one-cycle memory stall mid-flush
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);

        // Branch and load hazard together: branch wins
        applyStimulus(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

        // Branch reloaded while still flushing
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

        // Memory timeout, sticky until reset
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0);
        checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            busy_pct = (i < 400) ? 20 : 65;
            applyStimulus(($urandom_range(0, 99) >= 2),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < busy_pct));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
